// File: rtl/somador_serial_6bits.sv
// Bit-serial WIDTH-bit adder: one full-adder stage, a carry flip-flop and a start/busy/done FSM.
// Optional signed-overflow output `transbordo` is built when SOMADOR_OVERFLOW_EN is defined.
module somador_serial_6bits #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inicio,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             vaiUmEntrada,
    output logic             ocupado,
    output logic             pronto,
    output logic [WIDTH-1:0] soma,
    output logic             vaiUmFinal
`ifdef SOMADOR_OVERFLOW_EN
    ,
    output logic             transbordo
`endif
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StOcioso  = 2'd0,
        StSomando = 2'd1,
        StPronto  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] soma_q, soma_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             vai_um_q, vai_um_d;
    logic             bit_s, bit_c;
`ifdef SOMADOR_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    // Single full-adder stage on the current LSBs of the operand shift registers.
    always_comb begin
        bit_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        bit_c = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        soma_d   = soma_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        vai_um_d = vai_um_q;
`ifdef SOMADOR_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StOcioso: begin
                if (inicio) begin
                    state_d  = StSomando;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    c_d      = vaiUmEntrada;
                    cnt_d    = '0;
                    soma_d   = '0;
                    vai_um_d = 1'b0;
`ifdef SOMADOR_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            StSomando: begin
                // Sum bits enter from the MSB side so bit i settles in soma[i] after WIDTH shifts.
                soma_d = {bit_s, soma_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = bit_c;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d  = StPronto;
                    vai_um_d = bit_c;
`ifdef SOMADOR_OVERFLOW_EN
                    // c_q is the carry into the MSB, bit_c the carry out of it.
                    ovf_d    = c_q ^ bit_c;
`endif
                end
            end
            StPronto: begin
                state_d = StOcioso;
            end
            default: begin
                state_d = StOcioso;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StOcioso;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            soma_q   <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            vai_um_q <= 1'b0;
`ifdef SOMADOR_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            soma_q   <= soma_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            vai_um_q <= vai_um_d;
`ifdef SOMADOR_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        ocupado    = (state_q == StSomando);
        pronto     = (state_q == StPronto);
        soma       = soma_q;
        vaiUmFinal = vai_um_q;
`ifdef SOMADOR_OVERFLOW_EN
        transbordo = ovf_q;
`endif
    end

    busy_done_exclusive: assert property (@(posedge clock) !(ocupado && pronto));

endmodule

// File: tb/tb_somador_serial_6bits.sv
// Self-checking bench for somador_serial_6bits: directed plan plus random operands
// compared against an integer-arithmetic reference model.
module tb_somador_serial_6bits;

    logic       clock;
    logic       reset;
    logic       inicio;
    logic [5:0] a;
    logic [5:0] b;
    logic       vaiUmEntrada;
    logic       ocupado;
    logic       pronto;
    logic [5:0] soma;
    logic       vaiUmFinal;
    logic       transbordo;

    int checks = 0;
    int errors = 0;

    somador_serial_6bits #(
        .WIDTH(6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .inicio      (inicio),
        .a           (a),
        .b           (b),
        .vaiUmEntrada(vaiUmEntrada),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .soma        (soma),
        .vaiUmFinal  (vaiUmFinal)
`ifdef SOMADOR_OVERFLOW_EN
        ,
        .transbordo  (transbordo)
`endif
    );

`ifndef SOMADOR_OVERFLOW_EN
    assign transbordo = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ocupado"}, 32'(ocupado), 0);
        check({tag, "_pronto"}, 32'(pronto), 0);
        check({tag, "_soma"}, 32'(soma), 0);
        check({tag, "_vaiUm"}, 32'(vaiUmFinal), 0);
`ifdef SOMADOR_OVERFLOW_EN
        check({tag, "_transbordo"}, 32'(transbordo), 0);
`endif
    endtask

    // Full transaction: accept, count busy cycles, check result at pronto and the return to idle.
    task automatic run_op(input logic [5:0] ta, input logic [5:0] tb, input logic tc,
                          input string tag);
        int         k;
        int         busy;
        int         total;
        int         sa;
        int         sb;
        int         ssum;
        logic       exp_ovf;
        total   = int'(ta) + int'(tb) + int'(tc);
        sa      = ta[5] ? int'(ta) - 64 : int'(ta);
        sb      = tb[5] ? int'(tb) - 64 : int'(tb);
        ssum    = sa + sb + int'(tc);
        exp_ovf = (ssum > 31) || (ssum < -32);

        @(negedge clock);
        a = ta; b = tb; vaiUmEntrada = tc; inicio = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        a = 6'($urandom); b = 6'($urandom); vaiUmEntrada = 1'($urandom);
        k = -1;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (pronto) begin
                k = i;
                break;
            end
            if (ocupado) busy++;
            @(posedge clock);
            #1;
        end
        check({tag, "_latency"}, k, 6);
        check({tag, "_busy_cycles"}, busy, 6);
        check({tag, "_soma"}, 32'(soma), total % 64);
        check({tag, "_vaiUm"}, 32'(vaiUmFinal), total / 64);
`ifdef SOMADOR_OVERFLOW_EN
        check({tag, "_transbordo"}, 32'(transbordo), 32'(exp_ovf));
`endif
        @(posedge clock);
        #1;
        check({tag, "_pronto_pulse"}, 32'(pronto), 0);
        check({tag, "_idle"}, 32'(ocupado), 0);
        check({tag, "_soma_held"}, 32'(soma), total % 64);
    endtask

    initial begin
        reset = 1'b1; inicio = 1'b0; a = '0; b = '0; vaiUmEntrada = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_idle_zero("idle");
        end

        run_op(6'b010101, 6'b001010, 1'b0, "alt");
        run_op(6'b111111, 6'b000001, 1'b0, "wrap");
        run_op(6'b011111, 6'b000001, 1'b0, "ovf");
        run_op(6'b000000, 6'b000000, 1'b1, "cin_only");

        // inicio pulsed while busy and during pronto must be ignored.
        @(negedge clock);
        a = 6'b000001; b = 6'b000010; vaiUmEntrada = 1'b0; inicio = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("ign_busy3", 32'(ocupado), 1);
        inicio = 1'b1; a = 6'b111111; b = 6'b111111;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        check("ign_still_busy", 32'(ocupado), 1);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("ign_pronto", 32'(pronto), 1);
        check("ign_soma", 32'(soma), 3);
        check("ign_vaiUm", 32'(vaiUmFinal), 0);
        inicio = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        check("ign_no_restart", 32'(ocupado), 0);
        check("ign_soma_held", 32'(soma), 3);

        // Reset mid-operation discards all partial state.
        @(negedge clock);
        a = 6'b111111; b = 6'b111111; vaiUmEntrada = 1'b1; inicio = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("rst_busy3", 32'(ocupado), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle_zero("rst_mid");
        run_op(6'b000010, 6'b000011, 1'b0, "post_rst");

        for (int n = 0; n < 24; n++) begin
            run_op(6'($urandom), 6'($urandom), 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
